// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main FSM: state enum and datapath select constants.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } mc_state_t;

    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic ADR_PC  = 1'b0;
    localparam logic ADR_ALU = 1'b1;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational lookup from the registered FSM state to the Moore control word.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  logic [3:0] state_i,
    output logic       fetch_o,
    output logic       adr_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output logic       alu_op_o,
    output logic       reg_w_o,
    output logic       mem_w_o,
    output logic       branch_o
);

    always_comb begin
        fetch_o      = 1'b0;
        adr_src_o    = ADR_PC;
        alu_src_a_o  = SRCA_REG;
        alu_src_b_o  = SRCB_REG;
        result_src_o = RES_ALUOUT;
        alu_op_o     = 1'b0;
        reg_w_o      = 1'b0;
        mem_w_o      = 1'b0;
        branch_o     = 1'b0;
        case (mc_state_t'(state_i))
            StFetch: begin
                fetch_o      = 1'b1;
                alu_src_a_o  = SRCA_PC;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALU;
            end
            // PC+8 is formed here for use as R15 by the instruction
            StDecode: begin
                alu_src_a_o  = SRCA_PC;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALU;
            end
            StMemAdr: begin
                alu_src_b_o = SRCB_IMM;
            end
            StMemRead: begin
                adr_src_o = ADR_ALU;
            end
            StMemWb: begin
                result_src_o = RES_RDATA;
                reg_w_o      = 1'b1;
            end
            StMemWrite: begin
                adr_src_o = ADR_ALU;
                mem_w_o   = 1'b1;
            end
            StExecR: begin
                alu_op_o = 1'b1;
            end
            StExecI: begin
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = 1'b1;
            end
            // ALU function held through writeback so flags/result stay consistent
            StAluWb: begin
                result_src_o = RES_ALUOUT;
                alu_op_o     = 1'b1;
                reg_w_o      = 1'b1;
            end
            StBranch: begin
                alu_src_a_o  = SRCA_ALUOUT;
                alu_src_b_o  = SRCB_IMM;
                result_src_o = RES_ALU;
                branch_o     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Main sequencing FSM for the multicycle datapath; MC_MEM_WAIT_EN enables mem_ready wait states,
// otherwise memory is treated as single-cycle and mem_ready is ignored.
module mc_main_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       undef,
    output logic [3:0] state
);

    mc_state_t state_q, state_d;
    logic      mem_ok;
    logic      fetch;

`ifdef MC_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    state_d = mem_ok ? StDecode : StFetch;
            StDecode: begin
                unique case (Op)
                    2'b00:   state_d = Funct[5] ? StExecI : StExecR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = Funct[0] ? StMemRead : StMemWrite;
            StMemRead:  state_d = mem_ok ? StMemWb : StMemRead;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = mem_ok ? StFetch : StMemWrite;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    mc_ctrl_decode u_ctrl_decode (
        .state_i      (state_q),
        .fetch_o      (fetch),
        .adr_src_o    (AdrSrc),
        .alu_src_a_o  (ALUSrcA),
        .alu_src_b_o  (ALUSrcB),
        .result_src_o (ResultSrc),
        .alu_op_o     (ALUOp),
        .reg_w_o      (RegW),
        .mem_w_o      (MemW),
        .branch_o     (Branch)
    );

    // Gated by reset so no instruction latch or PC write can slip through while held in reset
    assign IRWrite = fetch & mem_ok & reset;
    assign NextPC  = fetch & mem_ok & reset;
    assign undef   = (state_q == StDecode) && (Op == 2'b11);
    assign state   = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Randomized self-checking bench for mc_main_fsm against an instruction-phase reference model.
module tb_mc_main_fsm;
    import mc_pkg::*;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch, undef;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    mc_main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .mem_ready (mem_ready),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .undef     (undef),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic eff_ready(input logic r);
`ifdef MC_MEM_WAIT_EN
        return r;
`else
        return r | 1'b1;
`endif
    endfunction

    function automatic logic waits_on_mem(input mc_state_t p);
        return (p == StFetch) || (p == StMemRead) || (p == StMemWrite);
    endfunction

    // {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, undef}
    function automatic logic [13:0] obs_word();
        return {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch,
                undef};
    endfunction

    // Expected outputs for one cycle spent in a given instruction phase
    function automatic logic [13:0] exp_word(input mc_state_t p, input logic ok, input logic [1:0] op);
        logic       irw, adr, aop, rw, mw, br, und;
        logic [1:0] a, b, res;
        {irw, adr, aop, rw, mw, br, und} = '0;
        a = 2'b00; b = 2'b00; res = 2'b00;
        case (p)
            StFetch:    begin irw = ok; a = 2'b01; b = 2'b10; res = 2'b10; end
            StDecode:   begin a = 2'b01; b = 2'b10; res = 2'b10; und = (op == 2'b11); end
            StMemAdr:   b = 2'b01;
            StMemRead:  adr = 1'b1;
            StMemWb:    begin res = 2'b01; rw = 1'b1; end
            StMemWrite: begin adr = 1'b1; mw = 1'b1; end
            StExecR:    aop = 1'b1;
            StExecI:    begin b = 2'b01; aop = 1'b1; end
            StAluWb:    begin aop = 1'b1; rw = 1'b1; end
            StBranch:   begin a = 2'b10; b = 2'b01; res = 2'b10; br = 1'b1; end
            default: ;
        endcase
        return {irw, irw, adr, a, b, res, aop, rw, mw, br, und};
    endfunction

    // Called at posedge+1; leaves at the following posedge+1
    task automatic do_cycle(input mc_state_t p, input logic rdy, output logic adv);
        logic ok;
        mem_ready = rdy;
        @(negedge clk);
        ok = eff_ready(rdy);
        check_eq("state", 32'(state), 32'(p));
        check_eq($sformatf("ctrl_%s", p.name()), 32'(obs_word()), 32'(exp_word(p, ok, Op)));
        adv = !waits_on_mem(p) || ok;
        @(posedge clk);
        #1;
    endtask

    // waits >= 0: that many not-ready cycles in MEMREAD/MEMWRITE; -1: random; -2: mem_ready tied 0
    task automatic run_insn(input logic [1:0] op, input logic [5:0] funct, input int waits,
                            output int ncyc);
        mc_state_t plan[$];
        logic      adv, r;
        int        w;
        Op = op;
        Funct = funct;
        ncyc = 0;
        plan.push_back(StFetch);
        plan.push_back(StDecode);
        case (op)
            2'b00: begin
                plan.push_back(funct[5] ? StExecI : StExecR);
                plan.push_back(StAluWb);
            end
            2'b01: begin
                plan.push_back(StMemAdr);
                if (funct[0]) begin
                    plan.push_back(StMemRead);
                    plan.push_back(StMemWb);
                end else begin
                    plan.push_back(StMemWrite);
                end
            end
            2'b10: plan.push_back(StBranch);
            default: ;
        endcase
        foreach (plan[i]) begin
            w = 0;
            do begin
                if (waits == -2) r = 1'b0;
                else if (waits < 0) r = (w > 20) ? 1'b1 : ($urandom_range(3) != 0);
                else if (plan[i] == StMemRead || plan[i] == StMemWrite) r = (w >= waits);
                else r = 1'b1;
                do_cycle(plan[i], r, adv);
                ncyc++;
                w++;
            end while (!adv);
        end
    endtask

    initial begin
        int  n;
        logic adv;
        reset = 1'b0;
        Op = 2'b00;
        Funct = 6'd0;
        mem_ready = 1'b1;
        #1;
        check_eq("reset_state", 32'(state), 32'(StFetch));
        check_eq("reset_ctrl", 32'(obs_word()), 32'(exp_word(StFetch, 1'b0, Op)));
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_insn(2'b00, 6'b001000, 0, n);
        check_eq("add_cycles", 32'(n), 32'd4);
        run_insn(2'b00, 6'b101000, 0, n);
        check_eq("addi_cycles", 32'(n), 32'd4);
        run_insn(2'b01, 6'b011001, 2, n);
`ifdef MC_MEM_WAIT_EN
        check_eq("ldr_wait_cycles", 32'(n), 32'd7);
`else
        check_eq("ldr_wait_cycles", 32'(n), 32'd5);
`endif
        run_insn(2'b01, 6'b011000, 1, n);
`ifdef MC_MEM_WAIT_EN
        check_eq("str_wait_cycles", 32'(n), 32'd5);
`else
        check_eq("str_wait_cycles", 32'(n), 32'd4);
`endif
        run_insn(2'b10, 6'b000000, 0, n);
        check_eq("b_cycles", 32'(n), 32'd3);
        run_insn(2'b11, 6'b010101, 0, n);
        check_eq("undef_cycles", 32'(n), 32'd2);

        // Reset asserted in the middle of a MEMREAD
        Op = 2'b01;
        Funct = 6'b011001;
        do_cycle(StFetch, 1'b1, adv);
        do_cycle(StDecode, 1'b1, adv);
        do_cycle(StMemAdr, 1'b1, adv);
        mem_ready = 1'b0;
        #2;
        check_eq("midread_state", 32'(state), 32'(StMemRead));
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_eq("midreset_state", 32'(state), 32'(StFetch));
        check_eq("midreset_ctrl", 32'(obs_word()), 32'(exp_word(StFetch, 1'b0, Op)));
        @(posedge clk);
        #1;
        check_eq("held_reset_state", 32'(state), 32'(StFetch));
        check_eq("held_reset_ctrl", 32'(obs_word()), 32'(exp_word(StFetch, 1'b0, Op)));
        reset = 1'b1;
        run_insn(2'b00, 6'b001000, 0, n);
        check_eq("post_reset_cycles", 32'(n), 32'd4);

`ifndef MC_MEM_WAIT_EN
        run_insn(2'b01, 6'b011001, -2, n);
        check_eq("ldr_tied0_cycles", 32'(n), 32'd5);
`endif

        for (int k = 0; k < 60; k++) begin
            run_insn(2'($urandom_range(3)), 6'($urandom_range(63)), -1, n);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
